// File: rtl/bip_pkg.sv
// Shared definitions for the BIP I sequencer: opcodes, FSM states,
// accumulator source encodings and ALU operation encodings.
package bip_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_ALU  = 2'b01;
    localparam logic [1:0] ACC_MEM  = 2'b10;
    localparam logic [1:0] ACC_IMM  = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        logic       needs_mem;
        logic       is_write;
        logic [1:0] acc_sel;
        logic       alu_op;
        logic       sel_b;
        logic       acc_we_en;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps an opcode onto the control fields
// the sequencer needs to route the instruction through its states.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    // Opcode lookup; anything outside the defined set is flagged illegal.
    always_comb begin
        dec.needs_mem  = 1'b0;
        dec.is_write   = 1'b0;
        dec.acc_sel    = ACC_NONE;
        dec.alu_op     = ALU_ADD;
        dec.sel_b      = 1'b0;
        dec.acc_we_en  = 1'b0;
        dec.is_halt    = 1'b0;
        dec.is_illegal = 1'b0;
        case (opcode)
            OP_HLT: dec.is_halt = 1'b1;
            OP_STO: begin
                dec.needs_mem = 1'b1;
                dec.is_write  = 1'b1;
            end
            OP_LD: begin
                dec.needs_mem = 1'b1;
                dec.acc_sel   = ACC_MEM;
                dec.acc_we_en = 1'b1;
            end
            OP_LDI: begin
                dec.acc_sel   = ACC_IMM;
                dec.acc_we_en = 1'b1;
            end
            OP_ADD: begin
                dec.needs_mem = 1'b1;
                dec.acc_sel   = ACC_ALU;
                dec.acc_we_en = 1'b1;
            end
            OP_ADDI: begin
                dec.acc_sel   = ACC_ALU;
                dec.sel_b     = 1'b1;
                dec.acc_we_en = 1'b1;
            end
            OP_SUB: begin
                dec.needs_mem = 1'b1;
                dec.acc_sel   = ACC_ALU;
                dec.alu_op    = ALU_SUB;
                dec.acc_we_en = 1'b1;
            end
            OP_SUBI: begin
                dec.acc_sel   = ACC_ALU;
                dec.alu_op    = ALU_SUB;
                dec.sel_b     = 1'b1;
                dec.acc_we_en = 1'b1;
            end
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_sequencer.sv
// BIP I multi-cycle control unit: owns PC and IR, walks each instruction
// through FETCH/DECODE/MEM/WB and drives registered Moore control outputs.
module bip_sequencer
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = 11,
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [PC_WIDTH-1:0]   dmem_addr,
    output logic                  dmem_rd,
    output logic                  dmem_wr,
    input  logic                  dmem_ack,
    output logic                  alu_op,
    output logic                  sel_b,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [1:0]            acc_sel,
    output logic                  acc_we,
    input  logic                  resume,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic                    run_q;
    dec_t                    dec_s;

    logic imem_req_q, imem_req_d;
    logic dmem_rd_q, dmem_rd_d;
    logic dmem_wr_q, dmem_wr_d;
    logic acc_we_q, acc_we_d;
    logic illegal_q, illegal_d;
    logic halted_q, halted_d;
    logic alu_op_q, alu_op_d;
    logic sel_b_q, sel_b_d;
    logic [1:0] acc_sel_q, acc_sel_d;

    // Decoding the next IR lets the output registers line up with the state they describe.
    bip_decoder u_dec (
        .opcode (ir_d[DATA_WIDTH-1 -: OPCODE_WIDTH]),
        .dec    (dec_s)
    );

    // IR captures the instruction word on the fetch-ack edge only.
    always_comb begin
        if ((state_q == S_FETCH) && imem_ack) begin
            ir_d = imem_data;
        end else begin
            ir_d = ir_q;
        end
    end

    // Next-state and PC update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                // run_q holds off FETCH one edge so reset release is clean.
                if (run_q) state_d = S_FETCH;
                else       state_d = S_IDLE;
            end
            S_FETCH: begin
                if (imem_ack) state_d = S_DECODE;
                else          state_d = S_FETCH;
            end
            S_DECODE: begin
                if (dec_s.is_halt)        state_d = S_HALT;
                else if (dec_s.needs_mem) state_d = S_MEM;
                else                      state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack) state_d = S_WB;
                else          state_d = S_MEM;
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_ONE;
            end
            S_HALT: begin
                if (resume) begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PC_ONE;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs for the state being entered, registered below.
    always_comb begin
        imem_req_d = (state_d == S_FETCH);
        dmem_rd_d  = (state_d == S_MEM) && !dec_s.is_write;
        dmem_wr_d  = (state_d == S_MEM) && dec_s.is_write;
        acc_we_d   = (state_d == S_WB) && dec_s.acc_we_en;
        illegal_d  = (state_d == S_WB) && dec_s.is_illegal;
        halted_d   = (state_d == S_HALT);
        alu_op_d   = dec_s.alu_op;
        sel_b_d    = dec_s.sel_b;
        acc_sel_d  = dec_s.acc_sel;
    end

    // Architectural state: FSM, PC, IR and the reset-release stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= {PC_WIDTH{1'b0}};
            ir_q    <= {DATA_WIDTH{1'b0}};
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= 1'b1;
        end
    end

    // Output registers; async clear drops memory requests immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_req_q <= 1'b0;
            dmem_rd_q  <= 1'b0;
            dmem_wr_q  <= 1'b0;
            acc_we_q   <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
            alu_op_q   <= 1'b0;
            sel_b_q    <= 1'b0;
            acc_sel_q  <= 2'b00;
        end else begin
            imem_req_q <= imem_req_d;
            dmem_rd_q  <= dmem_rd_d;
            dmem_wr_q  <= dmem_wr_d;
            acc_we_q   <= acc_we_d;
            illegal_q  <= illegal_d;
            halted_q   <= halted_d;
            alu_op_q   <= alu_op_d;
            sel_b_q    <= sel_b_d;
            acc_sel_q  <= acc_sel_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_req  = imem_req_q;
    assign dmem_addr = ir_q[PC_WIDTH-1:0];
    assign dmem_rd   = dmem_rd_q;
    assign dmem_wr   = dmem_wr_q;
    assign acc_we    = acc_we_q;
    assign illegal   = illegal_q;
    assign halted    = halted_q;
    assign alu_op    = alu_op_q;
    assign sel_b     = sel_b_q;
    assign acc_sel   = acc_sel_q;
    assign imm       = {{(DATA_WIDTH-PC_WIDTH){ir_q[PC_WIDTH-1]}}, ir_q[PC_WIDTH-1:0]};

endmodule

// File: tb/tb_bip_sequencer.sv
// Self-checking bench for bip_sequencer: an instruction-level model expands
// each program into the expected per-cycle output trace, checked every cycle.
module tb_bip_sequencer;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DEC = 2, PH_MEM = 3, PH_WB = 4, PH_HALT = 5;

    typedef struct packed {
        logic        imem_req;
        logic [10:0] imem_addr;
        logic        dmem_rd;
        logic        dmem_wr;
        logic [10:0] dmem_addr;
        logic        acc_we;
        logic [1:0]  acc_sel;
        logic        alu_op;
        logic        sel_b;
        logic [15:0] imm;
        logic        halted;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [10:0] dmem_addr;
    logic        dmem_rd, dmem_wr;
    logic        dmem_ack = 1'b0;
    logic        alu_op, sel_b;
    logic [15:0] imm;
    logic [1:0]  acc_sel;
    logic        acc_we;
    logic        resume = 1'b0;
    logic        halted, illegal;

    logic [15:0] imem [0:2047];
    logic [15:0] dmem [0:2047];
    exp_t        exp_q[$];
    exp_t        act_s, cur_e;

    int tests = 0, fails = 0;
    int imem_wait = 0, dmem_wait = 0, halt_wait = 0;
    bit res_always = 1'b0, spur = 1'b0, cmp_en = 1'b0;
    int cyc, rd_cycles, wr_cycles, we_cycles, halt_cnt, ill_cnt;
    int first_we_cyc, last_we_cyc;
    logic [15:0] first_we_imm, acc_m, opnd;
    logic [1:0]  first_we_sel, last_we_sel;
    logic [10:0] halt_addr;

    always #5 clk = ~clk;

    bip_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ack(dmem_ack),
        .alu_op(alu_op), .sel_b(sel_b), .imm(imm), .acc_sel(acc_sel), .acc_we(acc_we),
        .resume(resume), .halted(halted), .illegal(illegal)
    );

    assign act_s = {imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, acc_we, acc_sel,
                    alu_op, sel_b, imm, halted, illegal};

    // Outputs expected in a given instruction phase, straight from the opcode table.
    function automatic exp_t mk(input int ph, input logic [10:0] pc, input logic [15:0] ir);
        exp_t e;
        logic [4:0] op;
        op = ir[15:11];
        e.imem_req  = (ph == PH_FETCH);
        e.imem_addr = pc;
        e.dmem_rd   = (ph == PH_MEM) && (op == 5'd2 || op == 5'd4 || op == 5'd6);
        e.dmem_wr   = (ph == PH_MEM) && (op == 5'd1);
        e.dmem_addr = ir[10:0];
        e.acc_we    = (ph == PH_WB) && (op >= 5'd2) && (op <= 5'd7);
        if (op == 5'd2)                      e.acc_sel = 2'b10;
        else if (op == 5'd3)                 e.acc_sel = 2'b11;
        else if (op >= 5'd4 && op <= 5'd7)   e.acc_sel = 2'b01;
        else                                 e.acc_sel = 2'b00;
        e.alu_op    = (op == 5'd6 || op == 5'd7);
        e.sel_b     = (op == 5'd5 || op == 5'd7);
        e.imm       = {{5{ir[10]}}, ir[10:0]};
        e.halted    = (ph == PH_HALT);
        e.illegal   = (ph == PH_WB) && (op >= 5'd8);
        return e;
    endfunction

    // Expand n instructions from PC 0 into a per-cycle trace using the latency rules.
    task automatic gen(input int n, input int iw, input int dw, input int hw, input bit ra);
        logic [10:0] pc;
        logic [15:0] ir;
        logic [4:0]  op;
        pc = 11'd0;
        ir = 16'h0000;
        exp_q.push_back(mk(PH_IDLE, pc, ir));
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w <= iw; w++) exp_q.push_back(mk(PH_FETCH, pc, ir));
            ir = imem[pc];
            op = ir[15:11];
            exp_q.push_back(mk(PH_DEC, pc, ir));
            if (op == 5'd0) begin
                for (int w = 0; w <= (ra ? 0 : hw); w++) exp_q.push_back(mk(PH_HALT, pc, ir));
            end else begin
                if (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6)
                    for (int w = 0; w <= dw; w++) exp_q.push_back(mk(PH_MEM, pc, ir));
                exp_q.push_back(mk(PH_WB, pc, ir));
            end
            pc = pc + 11'd1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic run(input int n, input int iw, input int dw, input int hw, input bit ra, input bit sp);
        int budget;
        cmp_en = 1'b0;
        exp_q.delete();
        imem_wait = iw; dmem_wait = dw; halt_wait = hw; res_always = ra; spur = sp;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_outputs", 64'(act_s), 64'd0);
        repeat (2) @(negedge clk);
        cyc = 0; rd_cycles = 0; wr_cycles = 0; we_cycles = 0; halt_cnt = 0; ill_cnt = 0;
        first_we_cyc = -1; last_we_cyc = -1; acc_m = 16'h0000; halt_addr = 11'h7FF;
        gen(n, iw, dw, hw, ra);
        reset_n = 1'b1;
        @(posedge clk);
        cmp_en = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL trace_timeout: %0d entries left, required 0", exp_q.size());
        end
        cmp_en = 1'b0;
    endtask

    // Instruction memory responder: acks after imem_wait cycles of request.
    initial begin : imem_resp
        int icnt;
        icnt = 0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (icnt == imem_wait) begin
                    imem_ack = 1'b1; imem_data = imem[imem_addr]; icnt = 0;
                end else begin
                    imem_ack = 1'b0; icnt++;
                end
            end else begin
                imem_ack = 1'b0; icnt = 0;
            end
        end
    end

    // Data memory responder, optionally throwing acks while nothing is requested.
    initial begin : dmem_resp
        int dcnt;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (dmem_rd || dmem_wr) begin
                if (dcnt == dmem_wait) begin
                    dmem_ack = 1'b1; dcnt = 0;
                end else begin
                    dmem_ack = 1'b0; dcnt++;
                end
            end else begin
                dmem_ack = spur; dcnt = 0;
            end
        end
    end

    // Resume driver: pulse after halt_wait+1 HALT cycles, or hold high throughout.
    initial begin : resume_drv
        int hcnt;
        hcnt = 0;
        forever begin
            @(negedge clk);
            if (res_always) begin
                resume = 1'b1;
            end else if (halted) begin
                resume = (hcnt == halt_wait); hcnt++;
            end else begin
                resume = 1'b0; hcnt = 0;
            end
        end
    end

    // Per-cycle trace comparison plus accumulator model and event counters.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en && exp_q.size() > 0) begin
                cur_e = exp_q.pop_front();
                tests++;
                if (act_s !== cur_e) begin
                    fails++;
                    $display("FAIL trace cyc %0d: got %h expected %h", cyc, act_s, cur_e);
                end
                if (cur_e.acc_we) begin
                    opnd = cur_e.sel_b ? cur_e.imm : dmem[cur_e.dmem_addr];
                    if (cur_e.acc_sel == 2'b11)      acc_m = cur_e.imm;
                    else if (cur_e.acc_sel == 2'b10) acc_m = dmem[cur_e.dmem_addr];
                    else if (cur_e.alu_op)           acc_m = acc_m - opnd;
                    else                             acc_m = acc_m + opnd;
                end
                if (dmem_rd) rd_cycles++;
                if (dmem_wr) wr_cycles++;
                if (illegal) ill_cnt++;
                if (halted) begin halt_cnt++; halt_addr = imem_addr; end
                if (acc_we) begin
                    we_cycles++;
                    if (first_we_cyc < 0) begin
                        first_we_cyc = cyc; first_we_imm = imm; first_we_sel = acc_sel;
                    end
                    last_we_cyc = cyc; last_we_sel = acc_sel;
                end
                cyc++;
            end
        end
    end

    initial begin : main
        int budget;
        for (int i = 0; i < 2048; i++) begin imem[i] = 16'h0000; dmem[i] = 16'h0000; end

        // LDI 12 then HLT
        imem[0] = 16'h180C; imem[1] = 16'h0000;
        run(2, 0, 0, 3, 1'b0, 1'b0);
        chk("ldi_we_cycle", 64'(first_we_cyc), 64'd3);
        chk("ldi_imm", 64'(first_we_imm), 64'h000C);
        chk("ldi_acc_sel", 64'(first_we_sel), 64'd3);
        chk("ldi_halt_pc", 64'(halt_addr), 64'd1);
        chk("ldi_acc_model", 64'(acc_m), 64'd12);

        // LDI 12, ADDI 7, SUBI 15, HLT with a fetch wait state
        imem[0] = 16'h180C; imem[1] = 16'h2807; imem[2] = 16'h380F; imem[3] = 16'h0000;
        run(4, 1, 0, 1, 1'b0, 1'b0);
        chk("addi_subi_acc", 64'(acc_m), 64'd4);

        // LDI 3, ADD 0x005 with ack delayed 3 cycles and stray data acks
        dmem[5] = 16'h0010;
        imem[0] = 16'h1803; imem[1] = 16'h2005; imem[2] = 16'h0000;
        run(3, 0, 3, 0, 1'b0, 1'b1);
        chk("add_rd_cycles", 64'(rd_cycles), 64'd4);
        chk("add_we_cycle", 64'(last_we_cyc), 64'd10);
        chk("add_acc_sel", 64'(last_we_sel), 64'd1);
        chk("add_acc_model", 64'(acc_m), 64'h0013);

        // STO 0x7FF, HLT, resume pulse, LDI 1
        imem[0] = 16'h0FFF; imem[1] = 16'h0000; imem[2] = 16'h1801;
        run(3, 0, 2, 2, 1'b0, 1'b0);
        chk("sto_wr_cycles", 64'(wr_cycles), 64'd3);
        chk("sto_we_count", 64'(we_cycles), 64'd1);
        chk("sto_halt_pc", 64'(halt_addr), 64'd1);

        // resume held high: each HLT leaves HALT after one cycle
        imem[0] = 16'h1802; imem[1] = 16'h0000; imem[2] = 16'h1805; imem[3] = 16'h0000; imem[4] = 16'h1809;
        run(5, 0, 0, 0, 1'b1, 1'b0);
        chk("resume_held_halt_cycles", 64'(halt_cnt), 64'd2);
        chk("resume_held_acc", 64'(acc_m), 64'd9);

        // Undefined opcode at PC 2047 and wrap to 0
        for (int i = 0; i < 2047; i++) imem[i] = {5'b00011, i[10:0]};
        imem[2047] = 16'hFFFF;
        run(2049, 0, 0, 0, 1'b0, 1'b0);
        chk("wrap_illegal_count", 64'(ill_cnt), 64'd1);
        chk("wrap_we_count", 64'(we_cycles), 64'd2048);

        // Reset asserted mid-MEM of LD 0x003
        imem[0] = 16'h1003; dmem[3] = 16'hBEEF;
        cmp_en = 1'b0; imem_wait = 0; dmem_wait = 5; res_always = 1'b0; spur = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        repeat (2) @(negedge clk); reset_n = 1'b1;
        budget = 0;
        while (!dmem_rd && budget < 20) begin @(negedge clk); budget++; end
        chk("ld_reached_mem", 64'(dmem_rd), 64'd1);
        #2; reset_n = 1'b0; #1;
        chk("async_drop_rd", 64'(dmem_rd), 64'd0);
        chk("async_pc_zero", 64'(imem_addr), 64'd0);
        chk("async_no_we", 64'(acc_we), 64'd0);
        run(1, 0, 0, 0, 1'b0, 1'b0);
        chk("ld_restart_acc", 64'(acc_m), 64'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
